// File: rtl/wash_timer_if.sv
// Bundle of signals between the wash controller and the wash_timer sequencer.
// master : drives the run request (on) and pause; observes phase, digits, status.
// slave  : the timer itself; samples on/pause and drives phase, BCD digits,
//          busy and the one-cycle done pulse.
interface wash_timer_if;
  logic       on;     // run request, synchronous and debounced
  logic       pause;  // level, freezes timing while running
  logic [1:0] st;     // phase: 00 WASH, 01 RINSE, 10 SPIN, 11 IDLE
  logic [3:0] n3;     // BCD tens of minutes
  logic [3:0] n2;     // BCD minutes
  logic [3:0] n1;     // BCD tens of seconds (0..5)
  logic [3:0] n0;     // BCD seconds
  logic       busy;   // high in WASH/RINSE/SPIN
  logic       done;   // one-cycle pulse on normal completion

  modport master (
    output on, pause,
    input  st, n3, n2, n1, n0, busy, done
  );

  modport slave (
    input  on, pause,
    output st, n3, n2, n1, n0, busy, done
  );
endinterface

// File: rtl/wash_timer.sv
// Washing-machine program sequencer and countdown timer.
// Runs WASH -> RINSE -> SPIN, counting each phase down in mm:ss BCD, one step
// per prescaled one-second tick.
// Ports:
//   clk   : system clock, all state on rising edge
//   rst_n : asynchronous active-low reset
//   tmr   : wash_timer_if.slave (on, pause in; st, n3..n0, busy, done out)
module wash_timer #(
  parameter int unsigned CLK_DIV = 100000000,
  parameter int unsigned WASH_S  = 90,
  parameter int unsigned RINSE_S = 60,
  parameter int unsigned SPIN_S  = 30
) (
  input  logic         clk,
  input  logic         rst_n,
  wash_timer_if.slave  tmr
);

  localparam int unsigned PW = $clog2(CLK_DIV);

  // Seconds -> {tens of min, min, tens of sec, sec} in BCD.
  function automatic logic [15:0] to_bcd(input int unsigned secs);
    int unsigned m;
    int unsigned s;
    m = secs / 60;
    s = secs % 60;
    return {4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10)};
  endfunction

  // One-second BCD decrement of mm:ss; seconds tens borrow wraps to 5.
  function automatic logic [15:0] bcd_dec(input logic [15:0] d);
    logic [3:0] a3, a2, a1, a0;
    {a3, a2, a1, a0} = d;
    if (a0 != 4'd0) begin
      a0 = a0 - 4'd1;
    end else begin
      a0 = 4'd9;
      if (a1 != 4'd0) begin
        a1 = a1 - 4'd1;
      end else begin
        a1 = 4'd5;
        if (a2 != 4'd0) begin
          a2 = a2 - 4'd1;
        end else begin
          a2 = 4'd9;
          a3 = a3 - 4'd1;
        end
      end
    end
    return {a3, a2, a1, a0};
  endfunction

  localparam logic [15:0] WASH_BCD  = to_bcd(WASH_S);
  localparam logic [15:0] RINSE_BCD = to_bcd(RINSE_S);
  localparam logic [15:0] SPIN_BCD  = to_bcd(SPIN_S);

  // Encoding matches the st output directly.
  typedef enum logic [1:0] {
    WASH  = 2'b00,
    RINSE = 2'b01,
    SPIN  = 2'b10,
    IDLE  = 2'b11
  } state_e;

  state_e          state_q;
  logic [15:0]     digits_q;
  logic [PW-1:0]   presc_q;
  logic            on_q;
  logic            busy_q;
  logic            done_q;

  logic            tick;
  logic [15:0]     digits_dec_d;

  // Tick detect and the decremented digit value for the current count.
  always_comb begin
    tick         = 1'b0;
    digits_dec_d = digits_q;
    if (presc_q == PW'(CLK_DIV - 1)) begin
      tick = 1'b1;
    end else begin
      tick = 1'b0;
    end
    digits_dec_d = bcd_dec(digits_q);
  end

  // Sequencer FSM with prescaler, digit countdown and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      digits_q <= 16'h0000;
      presc_q  <= {PW{1'b0}};
      on_q     <= 1'b1;  // an on held through reset must not start a cycle
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      on_q   <= tmr.on;
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (tmr.on && !on_q) begin
            state_q  <= WASH;
            busy_q   <= 1'b1;
            digits_q <= WASH_BCD;
            presc_q  <= {PW{1'b0}};
          end
        end
        WASH, RINSE, SPIN: begin
          // Abort wins over pause and any coincident tick or phase end.
          if (!tmr.on) begin
            state_q  <= IDLE;
            busy_q   <= 1'b0;
            digits_q <= 16'h0000;
            presc_q  <= {PW{1'b0}};
          end else if (!tmr.pause) begin
            if (tick) begin
              presc_q <= {PW{1'b0}};
              if (digits_q != 16'h0001) begin
                digits_q <= digits_dec_d;
              end else begin
                case (state_q)
                  WASH: begin
                    state_q  <= RINSE;
                    digits_q <= RINSE_BCD;
                  end
                  RINSE: begin
                    state_q  <= SPIN;
                    digits_q <= SPIN_BCD;
                  end
                  default: begin
                    state_q  <= IDLE;
                    busy_q   <= 1'b0;
                    digits_q <= 16'h0000;
                    done_q   <= 1'b1;
                  end
                endcase
              end
            end else begin
              presc_q <= presc_q + PW'(1);
            end
          end
        end
        default: begin
          state_q  <= IDLE;
          busy_q   <= 1'b0;
          digits_q <= 16'h0000;
          presc_q  <= {PW{1'b0}};
        end
      endcase
    end
  end

  assign tmr.st   = state_q;
  assign tmr.n3   = digits_q[15:12];
  assign tmr.n2   = digits_q[11:8];
  assign tmr.n1   = digits_q[7:4];
  assign tmr.n0   = digits_q[3:0];
  assign tmr.busy = busy_q;
  assign tmr.done = done_q;

endmodule

// File: tb/tb_wash_timer.sv
module tb_wash_timer;
  localparam int CLK_DIV = 4;
  localparam int WASH_S  = 3;
  localparam int RINSE_S = 2;
  localparam int SPIN_S  = 61;

  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_fail;

  wash_timer_if bus ();

  wash_timer #(
    .CLK_DIV (CLK_DIV),
    .WASH_S  (WASH_S),
    .RINSE_S (RINSE_S),
    .SPIN_S  (SPIN_S)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .tmr   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural model: phase index (3 = idle), remaining seconds, tick counter.
  int m_phase = 3;
  int m_rem   = 0;
  int m_cnt   = 0;
  bit m_onq   = 1'b1;
  bit m_done  = 1'b0;

  function automatic int dur(input int p);
    case (p)
      0:       return WASH_S;
      1:       return RINSE_S;
      default: return SPIN_S;
    endcase
  endfunction

  function automatic logic [15:0] secs_to_bcd(input int s);
    int m, r;
    m = s / 60;
    r = s % 60;
    return {4'(m / 10), 4'(m % 10), 4'(r / 10), 4'(r % 10)};
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_phase <= 3; m_rem <= 0; m_cnt <= 0; m_onq <= 1'b1; m_done <= 1'b0;
    end else begin
      m_onq  <= bus.on;
      m_done <= 1'b0;
      if (m_phase == 3) begin
        if (bus.on && !m_onq) begin
          m_phase <= 0; m_rem <= WASH_S; m_cnt <= 0;
        end
      end else if (!bus.on) begin
        m_phase <= 3; m_rem <= 0; m_cnt <= 0;
      end else if (!bus.pause) begin
        if (m_cnt == CLK_DIV - 1) begin
          m_cnt <= 0;
          if (m_rem > 1) m_rem <= m_rem - 1;
          else if (m_phase < 2) begin
            m_phase <= m_phase + 1; m_rem <= dur(m_phase + 1);
          end else begin
            m_phase <= 3; m_rem <= 0; m_done <= 1'b1;
          end
        end else begin
          m_cnt <= m_cnt + 1;
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  function automatic logic [31:0] dut_vec();
    return {8'h00, bus.st, bus.n3, bus.n2, bus.n1, bus.n0, bus.busy, bus.done};
  endfunction

  function automatic logic [31:0] mk_vec(input logic [1:0] s, input logic [15:0] d,
                                         input logic b, input logic dn);
    return {8'h00, s, d, b, dn};
  endfunction

  // Per-cycle compare of all outputs against the model.
  always @(negedge clk) begin
    chk("model", dut_vec(),
        mk_vec((m_phase == 3) ? 2'b11 : 2'(m_phase), secs_to_bcd(m_rem),
               (m_phase != 3), m_done));
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic lit(input string name, input logic [1:0] s, input logic [15:0] d,
                     input logic b, input logic dn);
    chk(name, dut_vec(), mk_vec(s, d, b, dn));
  endtask

  initial begin
    n_cmp = 0; n_fail = 0;
    rst_n = 1'b1; bus.on = 1'b1; bus.pause = 1'b0;
    #1 rst_n = 1'b0;
    step(3);
    rst_n = 1'b1;
    step(3);
    lit("reset_on_held", 2'b11, 16'h0000, 1'b0, 1'b0);

    // Run 1: full cycle.
    bus.on = 1'b0; step(1);
    bus.on = 1'b1; step(1);
    lit("wash_entry", 2'b00, 16'h0003, 1'b1, 1'b0);
    step(4); lit("wash_t1", 2'b00, 16'h0002, 1'b1, 1'b0);
    step(4); lit("wash_t2", 2'b00, 16'h0001, 1'b1, 1'b0);
    step(4); lit("rinse_entry", 2'b01, 16'h0002, 1'b1, 1'b0);
    step(4); lit("rinse_t1", 2'b01, 16'h0001, 1'b1, 1'b0);
    step(4); lit("spin_entry", 2'b10, 16'h0101, 1'b1, 1'b0);
    step(4); lit("spin_t1", 2'b10, 16'h0100, 1'b1, 1'b0);
    step(4); lit("spin_t2", 2'b10, 16'h0059, 1'b1, 1'b0);
    step(58 * 4); lit("spin_t60", 2'b10, 16'h0001, 1'b1, 1'b0);
    step(4); lit("spin_done", 2'b11, 16'h0000, 1'b0, 1'b1);
    step(1); lit("done_pulse_end", 2'b11, 16'h0000, 1'b0, 1'b0);

    // Run 2: pause mid-WASH, then abort in RINSE coincident with a tick.
    bus.on = 1'b0; step(1);
    bus.on = 1'b1; step(1);
    lit("wash2_entry", 2'b00, 16'h0003, 1'b1, 1'b0);
    step(4); lit("wash2_t1", 2'b00, 16'h0002, 1'b1, 1'b0);
    step(2);
    bus.pause = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step(1); lit("paused_hold", 2'b00, 16'h0002, 1'b1, 1'b0);
    end
    bus.pause = 1'b0;
    step(1); lit("resume_no_tick", 2'b00, 16'h0002, 1'b1, 1'b0);
    step(1); lit("resume_tick", 2'b00, 16'h0001, 1'b1, 1'b0);
    step(4); lit("rinse2_entry", 2'b01, 16'h0002, 1'b1, 1'b0);
    step(3);
    bus.on = 1'b0;
    step(1); lit("abort", 2'b11, 16'h0000, 1'b0, 1'b0);
    bus.on = 1'b1;
    step(1); lit("restart", 2'b00, 16'h0003, 1'b1, 1'b0);

    // Run 3: async reset between clock edges in SPIN.
    step(20); lit("spin3_entry", 2'b10, 16'h0101, 1'b1, 1'b0);
    step(5);
    #2 rst_n = 1'b0;
    #1 lit("async_reset", 2'b11, 16'h0000, 1'b0, 1'b0);
    step(1);
    rst_n = 1'b1;
    step(3); lit("post_reset_idle", 2'b11, 16'h0000, 1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule

// File: doc/wash_timer.md
Name: wash_timer

Overview:
- Program sequencer and countdown timer for the washing machine; sits directly upstream of the top-level display/lamp logic.
- Runs the fixed phase sequence WASH -> RINSE -> SPIN.
- Outputs the current phase on st[1:0], which the top level decodes into st_light.
- Outputs the remaining phase time as four BCD digits (mm:ss), which feed scan4 directly.

Parameters:
- CLK_DIV, 100000000, clk cycles per one-second tick (>=2)
- WASH_S, 90, wash phase duration in seconds (1..5999)
- RINSE_S, 60, rinse phase duration in seconds (1..5999)
- SPIN_S, 30, spin phase duration in seconds (1..5999)

Ports:
- clk  in  1  system clock; all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- on  in  1  run request, already synchronous and debounced; rising edge starts a cycle; low aborts
- pause  in  1  level; high freezes timing while running
- st  out  2  phase: 00 WASH, 01 RINSE, 10 SPIN, 11 IDLE
- n3  out  4  BCD tens of minutes
- n2  out  4  BCD minutes
- n1  out  4  BCD tens of seconds (0..5)
- n0  out  4  BCD seconds
- busy  out  1  high in WASH/RINSE/SPIN
- done  out  1  one-cycle pulse on normal completion

Behaviour:
- Clock and reset: one clock, clk. rst_n is asynchronous, active-low.
- Reset values:
  - st=11; n3..n0=0; busy=0; done=0.
  - Prescaler=0.
  - Registered copy on_q=1, so an "on" held high through reset does not start a cycle; a fresh rising edge is required.
- FSM states: IDLE, WASH, RINSE, SPIN.
  - The st encoding is as listed in Ports.
  - busy = (state != IDLE), registered with state.
- Start:
  - In IDLE, the cycle where on=1 and on_q=0 enters WASH.
  - Digits load the BCD mm:ss of WASH_S; prescaler clears to 0.
  - Entry latency: st=00 and digits are valid one cycle after the on edge.
  - Rising edges of on outside IDLE are ignored.
- Prescaler:
  - Counts 0..CLK_DIV-1 only while busy and pause=0.
  - tick is asserted when the count equals CLK_DIV-1; the count then wraps to 0.
  - First tick occurs CLK_DIV enabled cycles after phase entry.
- Countdown on tick:
  - If digits != 00:01: decrement mm:ss in BCD.
  - n0 0->9 borrows from n1.
  - n1 0->5 borrows from n2.
  - n2 0->9 borrows from n3.
  - Digits never leave BCD range; n1 never exceeds 5.
- Phase end on tick with digits == 00:01:
  - WASH -> RINSE: load RINSE_S.
  - RINSE -> SPIN: load SPIN_S.
  - SPIN -> IDLE: digits=00:00, done=1 for exactly that one cycle.
  - Each phase therefore lasts exactly its parameter value in ticks.
  - 00:00 is never displayed while busy.
  - Prescaler continues without a restart across phase boundaries.
- Pause:
  - While pause=1 and busy, the prescaler, digits and state hold.
  - Releasing pause resumes from the held prescaler value; no partial-second loss.
  - pause in IDLE has no effect.
- Abort:
  - on=0 while busy goes to IDLE next cycle; digits=00:00; prescaler=0; done stays 0.
  - Abort has priority over pause and over a coincident tick or phase end.
- Reset mid-operation: immediate return to reset values, regardless of phase or pause.
- Parameters:
  - Each duration converts to BCD mm:ss at elaboration: minutes = S/60, seconds = S%60.
  - Values outside 1..5999 are illegal.

Test Plan:
- Reset with on=1 held through deassertion -> st=11, digits 00:00, busy=0; no start until on goes 0 then 1.
- CLK_DIV=4, WASH_S=3, RINSE_S=2, SPIN_S=61; rising edge of on:
  - Next cycle st=00, digits 00:03.
  - After 4 cycles 00:02, after 8 cycles 00:01, after 12 cycles st=01 with 00:02.
- Same run into SPIN:
  - Entry shows 01:01; following ticks show 01:00, then 00:59.
  - 61st SPIN tick gives st=11, 00:00, done=1 for one cycle, busy=0.
- Pause: pause=1 for 10 cycles mid-WASH, 2 cycles after a tick -> digits and st frozen for those 10 cycles; next tick arrives 2 enabled cycles after release.
- Abort: on=0 in RINSE coincident with a tick -> next cycle st=11, 00:00, done=0; a later on rising edge restarts at WASH 00:03.
- Async reset asserted mid-SPIN, between clock edges -> outputs go to reset values immediately, without waiting for a clock edge.
